// File: rtl/popcount_stream_accum_if.sv
// Stream bundle for popcount_stream_accum: word input handshake and result output handshake.
interface popcount_stream_accum_if #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 16,
  parameter int BEAT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic [BEAT_W-1:0] out_beats;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_beats, out_ovf
  );
endinterface

// File: rtl/popcount_stream_accum.sv
// Two-stage pipelined popcount with per-word or per-frame accumulation and backpressure.
// Define POPCOUNT_STREAM_SAT_EN to clamp the accumulator at its maximum instead of wrapping.
module popcount_stream_accum #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 8,
  parameter int ACC_W   = 16,
  parameter int BEAT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  popcount_stream_accum_if.slave  s
);
  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int PC_W    = $clog2(CHUNK_W + 1);
  localparam int WC_W    = $clog2(DATA_W + 1);
  localparam int SUM_W   = ACC_W + 1;

  logic              advance;
  logic [PC_W-1:0]   part_d  [N_CHUNK];
  logic [PC_W-1:0]   s1_part [N_CHUNK];
  logic              s1_valid;
  logic              s1_mode;
  logic              s1_last;
  logic [WC_W-1:0]   wcnt;
  logic [SUM_W-1:0]  sum;
  logic              this_ovf;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0] beats;
  logic              ovf_sticky;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_count_q;
  logic [BEAT_W-1:0] out_beats_q;
  logic              out_ovf_q;

  // Whole pipeline moves together; in_ready must not look at in_valid.
  assign advance     = !out_valid_q || s.out_ready;
  assign s.in_ready  = advance;
  assign s.out_valid = out_valid_q;
  assign s.out_count = out_count_q;
  assign s.out_beats = out_beats_q;
  assign s.out_ovf   = out_ovf_q;

  always_comb begin
    for (int c = 0; c < N_CHUNK; c++) begin
      part_d[c] = '0;
      for (int b = 0; b < CHUNK_W; b++) begin
        part_d[c] = part_d[c] + PC_W'(s.in_data[c*CHUNK_W + b]);
      end
    end
  end

  always_comb begin
    wcnt = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      wcnt = wcnt + WC_W'(s1_part[c]);
    end
  end

  // Carry out of the extended sum is the overflow indication for this beat.
  assign sum      = {1'b0, acc} + SUM_W'(wcnt);
  assign this_ovf = sum[ACC_W];

`ifdef POPCOUNT_STREAM_SAT_EN
  assign acc_next = this_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_mode     <= 1'b0;
      s1_last     <= 1'b0;
      for (int c = 0; c < N_CHUNK; c++) s1_part[c] <= '0;
      acc         <= '0;
      beats       <= '0;
      ovf_sticky  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      s1_valid <= s.in_valid;
      s1_mode  <= s.in_mode;
      s1_last  <= s.in_last;
      for (int c = 0; c < N_CHUNK; c++) s1_part[c] <= part_d[c];

      if (s1_valid && !s1_mode) begin
        // Per-word results leave any open frame untouched.
        out_valid_q <= 1'b1;
        out_count_q <= ACC_W'(wcnt);
        out_beats_q <= BEAT_W'(1);
        out_ovf_q   <= 1'b0;
      end else if (s1_valid && !s1_last) begin
        acc         <= acc_next;
        beats       <= beats + 1'b1;
        ovf_sticky  <= ovf_sticky | this_ovf;
        out_valid_q <= 1'b0;
      end else if (s1_valid) begin
        out_valid_q <= 1'b1;
        out_count_q <= acc_next;
        out_beats_q <= beats + 1'b1;
        out_ovf_q   <= ovf_sticky | this_ovf;
        acc         <= '0;
        beats       <= '0;
        ovf_sticky  <= 1'b0;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_popcount_stream_accum.sv
// Self-checking bench for popcount_stream_accum: scoreboard queues fed by each test, drained by output monitors.
module tb_popcount_stream_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_stream_accum_if #(.DATA_W(64), .ACC_W(16), .BEAT_W(8)) a ();
  popcount_stream_accum_if #(.DATA_W(64), .ACC_W(10), .BEAT_W(8)) b ();

  popcount_stream_accum #(.DATA_W(64), .CHUNK_W(8), .ACC_W(16), .BEAT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .s   (a)
  );

  popcount_stream_accum #(.DATA_W(64), .CHUNK_W(8), .ACC_W(10), .BEAT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .s   (b)
  );

  typedef struct packed {
    logic [15:0] count;
    logic [7:0]  beats;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (!rst && a.out_valid && a.out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL out_a_unexpected: got count=%0d beats=%0d ovf=%0b, required no output",
                 a.out_count, a.out_beats, a.out_ovf);
      end else begin
        ea = qa.pop_front();
        if ({a.out_count, a.out_beats, a.out_ovf} !== {ea.count, ea.beats, ea.ovf}) begin
          errors++;
          $display("FAIL out_a: got count=%0d beats=%0d ovf=%0b, required count=%0d beats=%0d ovf=%0b",
                   a.out_count, a.out_beats, a.out_ovf, ea.count, ea.beats, ea.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b.out_valid && b.out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL out_b_unexpected: got count=%0d beats=%0d ovf=%0b, required no output",
                 b.out_count, b.out_beats, b.out_ovf);
      end else begin
        eb = qb.pop_front();
        if ({6'b0, b.out_count, b.out_beats, b.out_ovf} !== {eb.count, eb.beats, eb.ovf}) begin
          errors++;
          $display("FAIL out_b: got count=%0d beats=%0d ovf=%0b, required count=%0d beats=%0d ovf=%0b",
                   b.out_count, b.out_beats, b.out_ovf, eb.count, eb.beats, eb.ovf);
        end
      end
    end
  end

  task automatic send(input bit to_b, input logic [63:0] d, input logic m, input logic l);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    if (to_b) begin
      b.in_valid = 1'b1; b.in_data = d; b.in_mode = m; b.in_last = l;
    end else begin
      a.in_valid = 1'b1; a.in_data = d; a.in_mode = m; a.in_last = l;
    end
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = to_b ? b.in_ready : a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept", n);
    end
  endtask

  task automatic idle();
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a.out_valid, a.out_count, a.out_beats, a.out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got valid=%0b count=%0d beats=%0d ovf=%0b, required all 0",
               a.out_valid, a.out_count, a.out_beats, a.out_ovf);
    end
    checks++;
    if ({b.out_valid, b.out_count, b.out_beats, b.out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs: got valid=%0b count=%0d, required all 0", b.out_valid, b.out_count);
    end
    checks++;
    if (a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", a.in_ready);
    end
    rst = 1'b0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_per_word_latency();
    logic [63:0] words [3];
    logic [15:0] cnt [3];
    words = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};
    cnt   = '{16'd0, 16'd64, 16'd2};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        a.in_valid = 1'b1; a.in_data = words[k]; a.in_mode = 1'b0; a.in_last = 1'b0;
        qa.push_back('{count: cnt[k], beats: 8'd1, ovf: 1'b0});
      end else begin
        a.in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (k < 2) begin
        if (a.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early k=%0d: got out_valid=%0b, required 0", k, a.out_valid);
        end
      end else if (a.out_valid !== 1'b1 || a.out_count !== cnt[k-2]) begin
        errors++;
        $display("FAIL latency k=%0d: got valid=%0b count=%0d, required valid=1 count=%0d",
                 k, a.out_valid, a.out_count, cnt[k-2]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_valid_clear: got %0b, required 0", a.out_valid);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_frame();
    qa.push_back('{count: 16'd2, beats: 8'd1, ovf: 1'b0});
    send(1'b0, 64'h5, 1'b0, 1'b1);
    qa.push_back('{count: 16'd80, beats: 8'd3, ovf: 1'b0});
    send(1'b0, 64'hFF, 1'b1, 1'b0);
    send(1'b0, 64'hF0F0, 1'b1, 1'b0);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] snap_c;
    logic [7:0]  snap_b;
    qa.push_back('{count: 16'd1,  beats: 8'd1, ovf: 1'b0});
    qa.push_back('{count: 16'd2,  beats: 8'd1, ovf: 1'b0});
    qa.push_back('{count: 16'd3,  beats: 8'd1, ovf: 1'b0});
    qa.push_back('{count: 16'd16, beats: 8'd1, ovf: 1'b0});
    fork
      begin
        send(1'b0, 64'h1, 1'b0, 1'b0);
        send(1'b0, 64'h3, 1'b0, 1'b0);
        send(1'b0, 64'h7, 1'b0, 1'b0);
        send(1'b0, 64'hFFFF, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        a.out_ready = 1'b0;
        @(negedge clk);
        snap_c = a.out_count;
        snap_b = a.out_beats;
        checks++;
        if (a.out_valid !== 1'b1 || snap_c !== 16'd1) begin
          errors++;
          $display("FAIL bp_first: got valid=%0b count=%0d, required valid=1 count=1", a.out_valid, snap_c);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++;
          if (a.in_ready !== 1'b0 || a.out_valid !== 1'b1 || a.out_count !== snap_c || a.out_beats !== snap_b) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d: got in_ready=%0b valid=%0b count=%0d, required 0/1/%0d",
                     i, a.in_ready, a.out_valid, a.out_count, snap_c);
          end
        end
        @(posedge clk);
        #2;
        a.out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_overflow();
`ifdef POPCOUNT_STREAM_SAT_EN
    qb.push_back('{count: 16'd1023, beats: 8'd17, ovf: 1'b1});
`else
    qb.push_back('{count: 16'd64, beats: 8'd17, ovf: 1'b1});
`endif
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, (i == 16));
    end
    idle();
    drain();
  endtask

  task automatic test_interleave();
    qa.push_back('{count: 16'd2, beats: 8'd1, ovf: 1'b0});
    qa.push_back('{count: 16'd5, beats: 8'd2, ovf: 1'b0});
    send(1'b0, 64'hF, 1'b1, 1'b0);
    send(1'b0, 64'h3, 1'b0, 1'b0);
    send(1'b0, 64'h1, 1'b1, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_reset_mid_frame();
    send(1'b0, 64'hFF, 1'b1, 1'b0);
    send(1'b0, 64'hFF, 1'b1, 1'b0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %0b, required 0", a.out_valid);
    end
    rst = 1'b0;
    qa.push_back('{count: 16'd1, beats: 8'd1, ovf: 1'b0});
    send(1'b0, 64'h1, 1'b1, 1'b1);
    idle();
    drain();
  endtask

  initial begin
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_data = '0; a.in_mode = 1'b0; a.in_last = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_mode = 1'b0; b.in_last = 1'b0; b.out_ready = 1'b0;
    test_reset();
    test_per_word_latency();
    test_frame();
    test_backpressure();
    test_overflow();
    test_interleave();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000");
    $fatal(1);
  end
endmodule

// File: doc/popcount_stream_accum.md
Name: popcount_stream_accum

Overview:
- Pipelined, parametrised population counter: successor to the 64-input combinational bit-count block.
- Accepts a stream of DATA_W-bit words over a valid/ready handshake.
- Returns either a per-word ones count or a per-frame accumulated count, with a beat count and an overflow flag.
- Sits between a packet/bitmap source and a downstream consumer that applies backpressure.

Parameters:
DATA_W, 64, input word width; any value >= 2
CHUNK_W, 8, stage-1 partial-popcount chunk width; DATA_W must be a multiple of CHUNK_W
ACC_W, 16, accumulator/result width; must be >= clog2(DATA_W+1)
BEAT_W, 8, frame beat-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  DATA_W  word to count
in_last  in  1  last beat of frame (used only in frame mode)
in_mode  in  1  0 = per-word, 1 = frame-accumulate; sampled per beat
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_count  out  ACC_W  ones count (word or frame)
out_beats  out  BEAT_W  beats in frame (1 in per-word mode)
out_ovf  out  1  accumulator wrapped or saturated during this frame

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_count=0, out_beats=0, out_ovf=0, all stage valids=0, accumulator=0, beat counter=0, overflow sticky=0.
- Reset mid-frame discards the partial frame; no output is produced for it.
- Pipeline stall rule:
  - advance = !out_valid | out_ready.
  - in_ready = advance, combinational, with no dependency on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - All stages shift only on advance; on stall every register holds.
- Stage 1 (S1): registers DATA_W/CHUNK_W partial counts, each clog2(CHUNK_W+1) bits, plus mode, last and valid.
- Stage 2 (S2): sums the partials into wcnt (clog2(DATA_W+1) bits, zero-extended to ACC_W), then updates the output registers.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+2 when there is no stall.
- Throughput: one beat per cycle.
- Per-word beat (mode=0):
  - out_count=wcnt, out_beats=1, out_ovf=0, out_valid=1.
  - The accumulator, beat counter and sticky flag are untouched, so per-word beats may interleave within an open frame.
- Frame beat (mode=1, last=0):
  - acc <= acc+wcnt; beats <= beats+1, wrapping mod 2^BEAT_W.
  - ovf_sticky is set if the sum exceeds 2^ACC_W-1.
  - No output is produced.
- Frame beat (mode=1, last=1):
  - out_count = acc+wcnt, computed with the same overflow rule.
  - out_beats = beats+1.
  - out_ovf = ovf_sticky | this-beat overflow.
  - out_valid=1.
  - Then acc, beats and ovf_sticky clear to 0 in the same cycle.
- A single-beat frame (last on the first beat) yields wcnt with out_beats=1.
- Default overflow handling: the sum wraps mod 2^ACC_W.
- Output holding: out_count, out_beats and out_ovf stay stable while out_valid=1 and out_ready=0.
- Output clearing: out_valid falls after a handshake only if S2 produces no new result.
- in_data=0 counts as 0. An all-ones word counts as DATA_W.
- in_last is ignored when in_mode=0.

Optional Feature:
- Macro: POPCOUNT_STREAM_SAT_EN.
- Defined: the accumulator and out_count clamp at 2^ACC_W-1 instead of wrapping. Further frame beats keep the value clamped. out_ovf still reports 1.
- Undefined: modulo-2^ACC_W wrap as above. The saturation logic is absent.

Test Plan:
- Reset, then per-word beats 0x0, 0xFFFF_FFFF_FFFF_FFFF, 0x8000_0000_0000_0001 back-to-back with out_ready=1 -> out_count 0, 64, 2 in cycles 2, 3, 4 after the first accept; out_beats=1; ovf=0.
- Frame of 3 beats (0xFF, 0xF0F0, all-ones; last on beat 3) -> single output out_count=80, out_beats=3, out_ovf=0; no output for beats 1-2.
- Backpressure: out_ready=0 for 5 cycles during a 4-word per-word stream -> in_ready drops; no beat lost or duplicated; outputs stay stable; the order is preserved after release.
- ACC_W=10, frame of 17 all-ones beats -> out_count=64, out_ovf=1 (wrap); with POPCOUNT_STREAM_SAT_EN defined -> out_count=1023, out_ovf=1.
- Interleave: frame beat (0xF, mode=1), per-word beat (0x3, mode=0), frame last (0x1, mode=1) -> outputs 2 (beats=1), then 5 (beats=2).
- Assert rst after 2 frame beats of 0xFF, then send a 1-beat frame of 0x1 -> out_count=1, out_beats=1; no stale accumulation.
